// File: rtl/param_updown_counter_pkg.sv
// Shared counter constants: overflow-handling mode selectors.
// Latency: n/a (constants only).
// Backpressure: n/a.
package counter_pkg;
  localparam int MODE_WRAP = 0;  // roll over at the limits
  localparam int MODE_SAT  = 1;  // hold at the limits
endpackage

// File: rtl/param_updown_counter_if.sv
// Control/status bundle of the up/down counter.
// Latency: n/a (wires only).
// Backpressure: none; the counter accepts a command every cycle.
interface param_updown_counter_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             ovf;

  // Controller side drives commands and observes the counter.
  modport master (output en, up, load, load_val, input count, tc, ovf);
  // Counter side.
  modport slave  (input en, up, load, load_val, output count, tc, ovf);
endinterface

// File: rtl/param_updown_counter_prescale_tick.sv
// Prescaler: emits one tick per PRESCALE enabled cycles.
// Latency: tick is combinational from en and the registered phase.
// Backpressure: none; en low freezes the phase, clr restarts it.
module prescale_tick #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  generate
    if (PRESCALE == 1) begin : g_bypass
      // No phase to track: every enabled cycle is a tick.
      logic unused_ok;
      assign unused_ok = ^{clk, rst, clr};
      assign tick      = en;
    end else begin : g_div
      localparam int            PW   = $clog2(PRESCALE);
      localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

      logic [PW-1:0] pre_cnt_q;
      logic [PW-1:0] pre_cnt_d;

      // Next phase: restart on clr, advance and wrap while enabled, else hold.
      always_comb begin
        pre_cnt_d = pre_cnt_q;
        if (clr) begin
          pre_cnt_d = '0;
        end else if (en) begin
          pre_cnt_d = (pre_cnt_q == LAST) ? '0 : pre_cnt_q + 1'b1;
        end
      end

      // Phase register with synchronous reset.
      always_ff @(posedge clk) begin
        if (rst) pre_cnt_q <= '0;
        else     pre_cnt_q <= pre_cnt_d;
      end

      assign tick = en & (pre_cnt_q == LAST);
    end
  endgenerate
endmodule

// File: rtl/param_updown_counter.sv
// Up/down counter, range 0..MAX_COUNT, with load, prescaler, wrap/saturate and sticky ovf.
// Latency: count/ovf update one cycle after a step or load; tc is combinational.
// Backpressure: none; rst > load > step > hold every cycle.
module param_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_COUNT = 2**WIDTH - 1,
  parameter int PRESCALE  = 1,
  parameter int MODE      = MODE_WRAP
) (
  input  logic                   clk,
  input  logic                   rst,
  param_updown_counter_if.slave  bus
);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             ovf_q;
  logic             ovf_d;
  logic             step;
  logic             at_limit;

  prescale_tick #(
    .PRESCALE (PRESCALE)
  ) u_prescale (
    .clk  (clk),
    .rst  (rst),
    .en   (bus.en),
    .clr  (bus.load),
    .tick (step)
  );

  // A step taken now would cross a limit in the current direction.
  always_comb begin
    at_limit = bus.up ? (count_q == MAX_V) : (count_q == '0);
  end

  // Next count/ovf: load clamps to MAX_COUNT; limit steps use explicit
  // compares because MAX_COUNT need not be 2**WIDTH-1.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (bus.load) begin
      count_d = (bus.load_val > MAX_V) ? MAX_V : bus.load_val;
      ovf_d   = 1'b0;
    end else if (step) begin
      if (at_limit) begin
        ovf_d = 1'b1;
        if (MODE == MODE_WRAP) begin
          count_d = bus.up ? '0 : MAX_V;
        end
      end else begin
        count_d = bus.up ? count_q + 1'b1 : count_q - 1'b1;
      end
    end
  end

  // State registers with synchronous reset overriding load and step.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.tc    = ~rst & ~bus.load & step & at_limit;
  assign bus.count = count_q;
  assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_param_updown_counter.sv
// Bench: four counter configurations driven by a shared command stream.
// Each is compared every cycle against a reference model.
// Directed steps first, then a randomized stream.
module tb_param_updown_counter;
  import counter_pkg::*;

  logic       clk = 1'b0;
  logic       rst, en, up, load;
  logic [3:0] load_val;
  logic [3:0] cnt_o [4];
  logic       tc_o  [4];
  logic       ovf_o [4];
  int         n_chk  = 0;
  int         n_pass = 0;

  // Reference model state per configuration
  int m_cnt [4];
  int m_pre [4];
  int m_ovf [4];

  always #5 clk = ~clk;

  // Configurations: 0 = 4-bit wrap, 1 = max 9 wrap, 2 = 4-bit sat, 3 = max 9 sat prescale 3
  function automatic int cfg_max(input int i);
    return (i == 1 || i == 3) ? 9 : 15;
  endfunction
  function automatic int cfg_pre(input int i);
    return (i == 3) ? 3 : 1;
  endfunction
  function automatic bit cfg_sat(input int i);
    return (i >= 2);
  endfunction

  param_updown_counter_if #(.WIDTH(4)) bi [4] ();

  generate
    for (genvar g = 0; g < 4; g++) begin : g_dut
      assign bi[g].en       = en;
      assign bi[g].up       = up;
      assign bi[g].load     = load;
      assign bi[g].load_val = load_val;
      assign cnt_o[g]       = bi[g].count;
      assign tc_o[g]        = bi[g].tc;
      assign ovf_o[g]       = bi[g].ovf;
      param_updown_counter #(
        .WIDTH     (4),
        .MAX_COUNT ((g == 1 || g == 3) ? 9 : 15),
        .PRESCALE  ((g == 3) ? 3 : 1),
        .MODE      ((g >= 2) ? MODE_SAT : MODE_WRAP)
      ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bi[g])
      );
    end
  endgenerate

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // One cycle: apply inputs after negedge, check tc, clock, check count/ovf.
  task automatic cyc(input bit r, input bit e, input bit u, input bit l, input int lv);
    rst = r; en = e; up = u; load = l; load_val = 4'(lv);
    #1;
    for (int i = 0; i < 4; i++) begin
      bit stp;
      bit lim;
      stp = e && (m_pre[i] == cfg_pre(i) - 1);
      lim = u ? (m_cnt[i] == cfg_max(i)) : (m_cnt[i] == 0);
      check($sformatf("tc[%0d]", i), int'(tc_o[i]), int'(!r && !l && stp && lim));
    end
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      int mx;
      mx = cfg_max(i);
      if (r) begin
        m_cnt[i] = 0; m_pre[i] = 0; m_ovf[i] = 0;
      end else if (l) begin
        m_cnt[i] = (lv > mx) ? mx : lv; m_pre[i] = 0; m_ovf[i] = 0;
      end else if (e) begin
        if (m_pre[i] == cfg_pre(i) - 1) begin
          m_pre[i] = 0;
          if (u) begin
            if (m_cnt[i] == mx) m_ovf[i] = 1;
            m_cnt[i] = cfg_sat(i) ? ((m_cnt[i] + 1 > mx) ? mx : m_cnt[i] + 1)
                                  : (m_cnt[i] + 1) % (mx + 1);
          end else begin
            if (m_cnt[i] == 0) m_ovf[i] = 1;
            m_cnt[i] = cfg_sat(i) ? ((m_cnt[i] == 0) ? 0 : m_cnt[i] - 1)
                                  : (m_cnt[i] + mx) % (mx + 1);
          end
        end else begin
          m_pre[i]++;
        end
      end
    end
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("count[%0d]", i), int'(cnt_o[i]), m_cnt[i]);
      check($sformatf("ovf[%0d]", i), int'(ovf_o[i]), m_ovf[i]);
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; load_val = 4'd0;
    for (int i = 0; i < 4; i++) begin
      m_cnt[i] = 0; m_pre[i] = 0; m_ovf[i] = 0;
    end
    @(negedge clk);

    // Reset state
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0);
    check("reset_count", int'(cnt_o[0]), 0);

    // Free run up: 4-bit wrap passes 15 -> 0 and sets ovf
    for (int k = 0; k < 16; k++) cyc(0, 1, 1, 0, 0);
    check("wrap16_count", int'(cnt_o[0]), 0);
    check("wrap16_ovf", int'(ovf_o[0]), 1);

    // MAX_COUNT 9: 8 -> 9 -> 0, then down from 0 -> 9
    cyc(0, 0, 1, 1, 8);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);
    check("max9_wrap_up", int'(cnt_o[1]), 0);
    cyc(0, 1, 0, 0, 0);
    check("max9_wrap_down", int'(cnt_o[1]), 9);
    cyc(0, 1, 0, 0, 0);

    // Saturate at 0 going down, then load clears ovf
    cyc(0, 0, 0, 1, 0);
    for (int k = 0; k < 3; k++) cyc(0, 1, 0, 0, 0);
    check("sat_low_count", int'(cnt_o[2]), 0);
    check("sat_low_ovf", int'(ovf_o[2]), 1);
    cyc(0, 0, 0, 1, 3);
    check("sat_load_ovf", int'(ovf_o[2]), 0);

    // Load clamps to MAX_COUNT; load beats a simultaneous step
    cyc(0, 1, 1, 1, 12);
    cyc(0, 1, 1, 1, 12);
    check("load_clamp", int'(cnt_o[1]), 9);

    // Prescale 3 with an en=0 gap mid-period
    cyc(0, 0, 1, 1, 0);
    for (int k = 0; k < 4; k++) cyc(0, 1, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    for (int k = 0; k < 5; k++) cyc(0, 1, 1, 0, 0);
    check("prescale_count", int'(cnt_o[3]), 3);

    // Reset overrides load and step in the same cycle
    cyc(0, 0, 1, 1, 7);
    cyc(1, 1, 1, 1, 5);
    check("rst_override", int'(cnt_o[0]), 0);

    // Randomized command stream
    for (int k = 0; k < 500; k++) begin
      cyc(($urandom % 40) == 0, ($urandom % 4) != 0, $urandom % 2,
          ($urandom % 10) == 0, int'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
